// File: rtl/atomrvcore_pkg.sv
// Shared types for the atomRVCORE memory-access stage.
package atomrvcore_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_e;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

endpackage

// File: rtl/atomrvcore_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables/data, load extraction/extension and
// misaligned/illegal access detection. Purely combinational.
module atomrvcore_lsu_align
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           size,
  input  logic [DATAWIDTH-1:0] store_data,
  input  logic [DATAWIDTH-1:0] load_word,
  output logic [3:0]           be,
  output logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] load_data,
  output logic                 misalign
);

  logic [DATAWIDTH-1:0] lane;

  // Shift the addressed byte/half down to bit 0 before extension.
  assign lane = load_word >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    misalign  = 1'b0;
    case (size)
      MEM_B, MEM_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {(DATAWIDTH/8){store_data[7:0]}};
      end
      MEM_H, MEM_HU: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {(DATAWIDTH/16){store_data[15:0]}};
        misalign = addr_lo[0];
      end
      MEM_W:   misalign = |addr_lo;
      default: misalign = 1'b1;
    endcase

    case (size)
      MEM_B:   load_data = {{(DATAWIDTH-8){lane[7]}}, lane[7:0]};
      MEM_BU:  load_data = {{(DATAWIDTH-8){1'b0}}, lane[7:0]};
      MEM_H:   load_data = {{(DATAWIDTH-16){lane[15]}}, lane[15:0]};
      MEM_HU:  load_data = {{(DATAWIDTH-16){1'b0}}, lane[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/atomrvcore_lsu.sv
// atomRVCORE memory-access stage: req/gnt/rvalid data bus master, pipeline stall,
// load alignment and writeback register.
module atomrvcore_lsu
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DATAWIDTH        = 32,
  parameter int unsigned REG_ADRESS_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DATAWIDTH-1:0]        result_i,
  input  logic [DATAWIDTH-1:0]        address_i,
  input  logic                        DR_EN_i,
  input  logic                        DWR_EN_i,
  input  logic [2:0]                  MEM_SIZE_i,
  input  logic [DATAWIDTH-1:0]        R2_i,
  input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
  input  logic                        RWR_EN_i,
  output logic                        data_req_o,
  input  logic                        data_gnt_i,
  output logic                        data_we_o,
  output logic [DATAWIDTH-1:0]        data_addr_o,
  output logic [3:0]                  data_be_o,
  output logic [DATAWIDTH-1:0]        data_wdata_o,
  input  logic                        data_rvalid_i,
  input  logic [DATAWIDTH-1:0]        data_rdata_i,
  output logic                        stall_o,
  output logic [REG_ADRESS_WIDTH-1:0] RD_m_o,
  output logic [DATAWIDTH-1:0]        wb_data_o,
  output logic [REG_ADRESS_WIDTH-1:0] RD_wb_o,
  output logic                        RWR_EN_o,
  output logic                        misalign_o,
  output logic                        bus_err_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e                  state_q;
  logic [DATAWIDTH-1:0]        addr_q;
  logic [2:0]                  size_q;
  logic [DATAWIDTH-1:0]        r2_q;
  logic [REG_ADRESS_WIDTH-1:0] rd_q;
  logic                        rwr_en_q;
  logic                        we_q;
  logic [CntW-1:0]             cnt_q;

  logic                        is_idle;
  logic                        mem_op;
  logic                        misalign;
  logic                        timeout_hit;
  logic [DATAWIDTH-1:0]        load_data;

  assign is_idle     = (state_q == IDLE);
  assign mem_op      = DR_EN_i | DWR_EN_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // In IDLE the aligner checks the incoming request; afterwards it works on latched copies.
  atomrvcore_lsu_align #(
    .DATAWIDTH(DATAWIDTH)
  ) u_align (
    .addr_lo   (is_idle ? address_i[1:0] : addr_q[1:0]),
    .size      (is_idle ? MEM_SIZE_i : size_q),
    .store_data(is_idle ? R2_i : r2_q),
    .load_word (data_rdata_i),
    .be        (data_be_o),
    .wdata     (data_wdata_o),
    .load_data (load_data),
    .misalign  (misalign)
  );

  assign data_req_o  = (state_q == REQ);
  assign data_we_o   = we_q;
  assign data_addr_o = {addr_q[DATAWIDTH-1:2], 2'b00};

  always_comb begin
    stall_o = 1'b0;
    RD_m_o  = '0;
    unique case (state_q)
      IDLE: begin
        stall_o = mem_op & ~misalign;
        RD_m_o  = (RWR_EN_i & ~DR_EN_i) ? RD_i : '0;
      end
      REQ:     stall_o = 1'b1;
      WAIT:    stall_o = ~data_rvalid_i;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      r2_q       <= '0;
      rd_q       <= '0;
      rwr_en_q   <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      wb_data_o  <= '0;
      RD_wb_o    <= '0;
      RWR_EN_o   <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (mem_op) begin
            RWR_EN_o <= 1'b0;
            if (misalign) begin
              misalign_o <= 1'b1;
            end else begin
              addr_q   <= address_i;
              size_q   <= MEM_SIZE_i;
              r2_q     <= R2_i;
              rd_q     <= RD_i;
              rwr_en_q <= RWR_EN_i;
              we_q     <= DWR_EN_i;
              state_q  <= REQ;
            end
          end else begin
            wb_data_o <= result_i;
            RD_wb_o   <= RD_i;
            RWR_EN_o  <= RWR_EN_i;
          end
        end
        REQ, WAIT: begin
          // A response arriving in the timeout cycle still completes normally.
          if (state_q == WAIT && data_rvalid_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (we_q) begin
              RWR_EN_o <= 1'b0;
            end else begin
              wb_data_o <= load_data;
              RD_wb_o   <= rd_q;
              RWR_EN_o  <= rwr_en_q;
            end
          end else if (timeout_hit) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            RWR_EN_o  <= 1'b0;
            bus_err_o <= 1'b1;
          end else begin
            if (TIMEOUT_CYCLES != 0) cnt_q <= cnt_q + CntW'(1);
            if (state_q == REQ && data_gnt_i) state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atomrvcore_lsu.sv
// Directed self-checking bench for atomrvcore_lsu with hand-computed expectations.
module tb_atomrvcore_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] result_i = '0;
  logic [31:0] address_i = '0;
  logic        DR_EN_i = 1'b0;
  logic        DWR_EN_i = 1'b0;
  logic [2:0]  MEM_SIZE_i = '0;
  logic [31:0] R2_i = '0;
  logic [4:0]  RD_i = '0;
  logic        RWR_EN_i = 1'b0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        stall_o;
  logic [4:0]  RD_m_o;
  logic [31:0] wb_data_o;
  logic [4:0]  RD_wb_o;
  logic        RWR_EN_o;
  logic        misalign_o;
  logic        bus_err_o;

  atomrvcore_lsu #(
    .DATAWIDTH       (32),
    .REG_ADRESS_WIDTH(5),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .result_i     (result_i),
    .address_i    (address_i),
    .DR_EN_i      (DR_EN_i),
    .DWR_EN_i     (DWR_EN_i),
    .MEM_SIZE_i   (MEM_SIZE_i),
    .R2_i         (R2_i),
    .RD_i         (RD_i),
    .RWR_EN_i     (RWR_EN_i),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_we_o    (data_we_o),
    .data_addr_o  (data_addr_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i),
    .stall_o      (stall_o),
    .RD_m_o       (RD_m_o),
    .wb_data_o    (wb_data_o),
    .RD_wb_o      (RD_wb_o),
    .RWR_EN_o     (RWR_EN_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One load or store through the bus; gnt after gnt_delay REQ cycles, rvalid the cycle after.
  task automatic mem_access(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] r2, input logic st, input logic [31:0] rdata,
                            input int gnt_delay, output int stalls, output logic [31:0] s_addr,
                            output logic [3:0] s_be, output logic [31:0] s_wdata,
                            output logic s_we);
    int req_n;
    bit gnt_given;
    bit done;
    req_n = 0; gnt_given = 0; done = 0; stalls = 0;
    s_addr = '0; s_be = '0; s_wdata = '0; s_we = 1'b0;
    @(negedge clk_i);
    address_i = addr; MEM_SIZE_i = size; R2_i = r2;
    DR_EN_i = ~st; DWR_EN_i = st; RD_i = 5'd7; RWR_EN_i = 1'b1; result_i = 32'h5555_AAAA;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk_i);
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (data_req_o) begin
        if (req_n == gnt_delay) begin
          data_gnt_i = 1'b1;
          gnt_given = 1;
        end
        req_n++;
      end else if (gnt_given) begin
        data_rvalid_i = 1'b1;
        data_rdata_i = rdata;
        done = 1;
      end
      #1;
      if (c == 0) check_eq("rd_m_first", RD_m_o, st ? 32'd7 : 32'd0);
      if (data_req_o && req_n == 1) begin
        s_addr = data_addr_o; s_be = data_be_o; s_wdata = data_wdata_o; s_we = data_we_o;
      end
      if (stall_o) stalls++;
    end
    check_eq("access_done", done, 1);
    @(negedge clk_i);
    data_rvalid_i = 1'b0; DR_EN_i = 1'b0; DWR_EN_i = 1'b0;
  endtask

  int          stalls;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_we;
  int          hit_at;

  initial begin
    // Reset
    repeat (2) @(negedge clk_i);
    check_eq("rst_req", data_req_o, 0);
    check_eq("rst_wb", wb_data_o, 0);
    check_eq("rst_rwr", RWR_EN_o, 0);
    check_eq("rst_rdwb", RD_wb_o, 0);
    check_eq("rst_stall", stall_o, 0);
    rst_ni = 1'b1;

    // Plain ALU op
    @(negedge clk_i);
    result_i = 32'h1234; RD_i = 5'd5; RWR_EN_i = 1'b1;
    #1;
    check_eq("alu_stall", stall_o, 0);
    check_eq("alu_rdm", RD_m_o, 5);
    @(negedge clk_i);
    check_eq("alu_wb", wb_data_o, 32'h1234);
    check_eq("alu_rdwb", RD_wb_o, 5);
    check_eq("alu_rwr", RWR_EN_o, 1);
    check_eq("alu_stall2", stall_o, 0);

    // LB, gnt on third REQ cycle
    mem_access(32'h103, 3'b000, 32'h0, 1'b0, 32'h80FF_0000, 2, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("lb_addr", s_addr, 32'h100);
    check_eq("lb_be", s_be, 4'b1000);
    check_eq("lb_we", s_we, 0);
    check_eq("lb_stalls", stalls, 4);
    check_eq("lb_wb", wb_data_o, 32'hFFFF_FF80);
    check_eq("lb_rwr", RWR_EN_o, 1);
    check_eq("lb_rdwb", RD_wb_o, 7);

    mem_access(32'h103, 3'b100, 32'h0, 1'b0, 32'h80FF_0000, 0, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("lbu_wb", wb_data_o, 32'h0000_0080);
    check_eq("lbu_stalls", stalls, 2);

    mem_access(32'h102, 3'b001, 32'h0, 1'b0, 32'h80FF_0000, 1, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("lh_be", s_be, 4'b1100);
    check_eq("lh_wb", wb_data_o, 32'hFFFF_80FF);

    mem_access(32'h100, 3'b101, 32'h0, 1'b0, 32'h1234_ABCD, 0, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("lhu_wb", wb_data_o, 32'h0000_ABCD);

    mem_access(32'h104, 3'b010, 32'h0, 1'b0, 32'hCAFE_BABE, 0, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("lw_addr", s_addr, 32'h104);
    check_eq("lw_be", s_be, 4'b1111);
    check_eq("lw_wb", wb_data_o, 32'hCAFE_BABE);

    // Stores
    mem_access(32'h22, 3'b001, 32'hABCD_5678, 1'b1, 32'h0, 1, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("sh_addr", s_addr, 32'h20);
    check_eq("sh_be", s_be, 4'b1100);
    check_eq("sh_wdata", s_wdata, 32'h5678_5678);
    check_eq("sh_we", s_we, 1);
    check_eq("sh_rwr", RWR_EN_o, 0);

    mem_access(32'h1, 3'b000, 32'h0000_00A5, 1'b1, 32'h0, 0, stalls, s_addr, s_be, s_wdata, s_we);
    check_eq("sb_be", s_be, 4'b0010);
    check_eq("sb_wdata", s_wdata, 32'hA5A5_A5A5);

    // Misaligned word, then illegal size
    @(negedge clk_i);
    DR_EN_i = 1'b1; MEM_SIZE_i = 3'b010; address_i = 32'h101; RWR_EN_i = 1'b1;
    result_i = 32'h9999;
    #1;
    check_eq("mis_stall", stall_o, 0);
    check_eq("mis_req", data_req_o, 0);
    @(negedge clk_i);
    check_eq("mis_pulse", misalign_o, 1);
    check_eq("mis_rwr", RWR_EN_o, 0);
    check_eq("mis_req2", data_req_o, 0);
    MEM_SIZE_i = 3'b011; address_i = 32'h100;
    #1;
    check_eq("ill_stall", stall_o, 0);
    @(negedge clk_i);
    check_eq("ill_pulse", misalign_o, 1);
    check_eq("ill_req", data_req_o, 0);
    DR_EN_i = 1'b0;
    @(negedge clk_i);
    check_eq("mis_clear", misalign_o, 0);
    check_eq("mis_after_wb", wb_data_o, 32'h9999);
    check_eq("mis_after_rwr", RWR_EN_o, 1);

    // Timeout with gnt never given
    DR_EN_i = 1'b1; MEM_SIZE_i = 3'b010; address_i = 32'h200; RWR_EN_i = 1'b1;
    hit_at = -1;
    for (int n = 1; n <= 40 && hit_at < 0; n++) begin
      @(negedge clk_i);
      if (n == 1) check_eq("to_req", data_req_o, 1);
      if (bus_err_o) hit_at = n;
    end
    DR_EN_i = 1'b0;
    #1;
    check_eq("to_cycles", hit_at - 1, 16);
    check_eq("to_req_drop", data_req_o, 0);
    check_eq("to_stall", stall_o, 0);
    check_eq("to_rwr", RWR_EN_o, 0);
    @(negedge clk_i);
    check_eq("to_pulse_end", bus_err_o, 0);

    // Reset while in WAIT, then a stray rvalid
    DR_EN_i = 1'b1; MEM_SIZE_i = 3'b010; address_i = 32'h300; RWR_EN_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    #1;
    check_eq("rw_wait_stall", stall_o, 1);
    rst_ni = 1'b0; DR_EN_i = 1'b0;
    #1;
    check_eq("rw_req", data_req_o, 0);
    check_eq("rw_stall", stall_o, 0);
    check_eq("rw_wb", wb_data_o, 0);
    check_eq("rw_rwr", RWR_EN_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    result_i = 32'h1111; RWR_EN_i = 1'b0; RD_i = 5'd3;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    check_eq("stray_rwr", RWR_EN_o, 0);
    check_eq("stray_wb", wb_data_o, 32'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
